xge_tx_pkt_arbiter: RTL and testbench

- Packet-level round-robin arbiter that lets NUM_SRC packet sources share the single pkt_tx_* transmit interface of the xge_mac core.
- Sits between the traffic sources (testcase drivers or user logic) and the MAC TX packet port, in the clk_156m25 domain.
- Grants a whole packet (sop..eop) at a time, never interleaves beats, and honours pkt_tx_full backpressure.

---
 rtl/xge_mac_pkg.sv | 19 +
 rtl/rr_priority_pick.sv | 35 +++
 rtl/xge_tx_pkt_arbiter.sv | 130 +++++++++++++
 tb/tb_xge_tx_pkt_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xge_mac_pkg.sv
// Shared types and constants for the xge_mac transmit-side helpers.
package xge_mac_pkg;

  localparam int XGE_DATA_W = 64;
  localparam int XGE_MOD_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [XGE_DATA_W-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [XGE_MOD_W-1:0]  mod;
  } tx_beat_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin first-set search: starting at rr_ptr and wrapping modulo
// NUM_SRC, return the first requesting index.
module rr_priority_pick #(
  parameter  int NUM_SRC = 4,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   rr_ptr,
  output logic               found,
  output logic [SRC_W-1:0]   idx
);

  logic [NUM_SRC-1:0] rot;
  logic [SRC_W:0]     sum;

  // Rotate so that rr_ptr lands on bit 0, then scan from the top down so the
  // lowest rotated position (closest to rr_ptr) is the last one written.
  always_comb begin
    rot   = NUM_SRC'({req, req} >> rr_ptr);
    found = 1'b0;
    idx   = rr_ptr;
    sum   = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
        if (sum >= (SRC_W + 1)'(NUM_SRC)) begin
          sum = sum - (SRC_W + 1)'(NUM_SRC);
        end
        found = 1'b1;
        idx   = sum[SRC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/xge_tx_pkt_arbiter.sv
// Packet-level round-robin arbiter in front of the xge_mac TX packet port.
// A source is granted from sop through eop; beats are forwarded with one
// cycle of latency and stall on pkt_tx_full.
module xge_tx_pkt_arbiter
  import xge_mac_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                            clk_156m25,
  input  logic                            reset_156m25_n,
  input  logic [NUM_SRC-1:0]              src_val,
  input  logic [NUM_SRC-1:0]              src_sop,
  input  logic [NUM_SRC-1:0]              src_eop,
  input  logic [XGE_MOD_W*NUM_SRC-1:0]    src_mod,
  input  logic [XGE_DATA_W*NUM_SRC-1:0]   src_data,
  output logic [NUM_SRC-1:0]              src_ready,
  input  logic                            pkt_tx_full,
  output logic                            pkt_tx_val,
  output logic                            pkt_tx_sop,
  output logic                            pkt_tx_eop,
  output logic [XGE_MOD_W-1:0]            pkt_tx_mod,
  output logic [XGE_DATA_W-1:0]           pkt_tx_data,
  output logic [SRC_W-1:0]                grant_idx,
  output logic                            busy,
  output logic [31:0]                     pkt_cnt
);

  arb_state_t         state_q, state_d;
  logic [SRC_W-1:0]   grant_q, grant_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  tx_beat_t           beat_q, beat_d;
  logic               val_q, val_d;
  logic [31:0]        pkt_cnt_q, pkt_cnt_d;

  tx_beat_t           src_beat [NUM_SRC];
  tx_beat_t           cur;
  logic [NUM_SRC-1:0] req;
  logic               pick_found;
  logic [SRC_W-1:0]   pick_idx;

  // Slice the flat per-source buses into one beat record per source.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_beat[i].data = src_data[XGE_DATA_W*i +: XGE_DATA_W];
      src_beat[i].sop  = src_sop[i];
      src_beat[i].eop  = src_eop[i];
      src_beat[i].mod  = src_mod[XGE_MOD_W*i +: XGE_MOD_W];
    end
  end

  // Only a source opening a packet may compete for the grant.
  assign req = src_val & src_sop;

  rr_priority_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // Next-state, grant, forwarding and ready logic for the IDLE/PKT FSM.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    beat_d    = beat_q;
    beat_d.sop = 1'b0;
    beat_d.eop = 1'b0;
    val_d     = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    src_ready = '0;
    cur       = src_beat[grant_q];
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = PKT;
        end
      end
      PKT: begin
        src_ready[grant_q] = !pkt_tx_full;
        if (src_val[grant_q] && !pkt_tx_full) begin
          val_d       = 1'b1;
          beat_d.data = cur.data;
          beat_d.sop  = cur.sop;
          beat_d.eop  = cur.eop;
          beat_d.mod  = cur.eop ? cur.mod : '0;
          if (cur.eop) begin
            state_d   = IDLE;
            rr_ptr_d  = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
            pkt_cnt_d = pkt_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything including the data path.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      beat_q    <= '0;
      val_q     <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      beat_q    <= beat_d;
      val_q     <= val_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign pkt_tx_val  = val_q;
  assign pkt_tx_sop  = beat_q.sop;
  assign pkt_tx_eop  = beat_q.eop;
  assign pkt_tx_mod  = beat_q.mod;
  assign pkt_tx_data = beat_q.data;
  assign grant_idx   = grant_q;
  assign busy        = (state_q == PKT);
  assign pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_xge_tx_pkt_arbiter.sv
// Bench for xge_tx_pkt_arbiter: directed scenarios plus a randomized
// packet-level run scored against a round-robin packet-order model.
module tb_xge_tx_pkt_arbiter;

  localparam int N = 4;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } sbeat_t;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    int          g;
    int          cyc;
  } obeat_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   src_val, src_sop, src_eop, src_ready;
  logic [3*N-1:0] src_mod;
  logic [64*N-1:0] src_data;
  logic           pkt_tx_full;
  logic           pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
  logic [2:0]     pkt_tx_mod;
  logic [63:0]    pkt_tx_data;
  logic [1:0]     grant_idx;
  logic           busy;
  logic [31:0]    pkt_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_src = -1;
  int exp_cnt = 0;

  sbeat_t srcq [N][$];
  sbeat_t refq [N][$];
  obeat_t outq [$];

  bit          armed = 1'b0;
  bit          pv = 1'b0;
  sbeat_t      pb;
  logic [63:0] last_d = '0;
  logic [2:0]  last_m = '0;

  always #5 clk = ~clk;

  xge_tx_pkt_arbiter #(.NUM_SRC(N)) dut (
    .clk_156m25     (clk),
    .reset_156m25_n (rst_n),
    .src_val        (src_val),
    .src_sop        (src_sop),
    .src_eop        (src_eop),
    .src_mod        (src_mod),
    .src_data       (src_data),
    .src_ready      (src_ready),
    .pkt_tx_full    (pkt_tx_full),
    .pkt_tx_val     (pkt_tx_val),
    .pkt_tx_sop     (pkt_tx_sop),
    .pkt_tx_eop     (pkt_tx_eop),
    .pkt_tx_mod     (pkt_tx_mod),
    .pkt_tx_data    (pkt_tx_data),
    .grant_idx      (grant_idx),
    .busy           (busy),
    .pkt_cnt        (pkt_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr();
    src_val = '0; src_sop = '0; src_eop = '0; src_mod = '0; src_data = '0;
    pkt_tx_full = 1'b0;
  endtask

  task automatic put(input int s, input sbeat_t b, input bit v);
    src_val[s] = v;
    src_sop[s] = b.sop;
    src_eop[s] = b.eop;
    src_mod[3*s +: 3] = b.mod;
    src_data[64*s +: 64] = b.d;
  endtask

  function automatic sbeat_t mk(input logic [63:0] d, input bit sop, input bit eop, input logic [2:0] mod);
    sbeat_t b;
    b.d = d; b.sop = sop; b.eop = eop; b.mod = mod;
    return b;
  endfunction

  // Negedge observer: any beat accepted in a cycle must appear on pkt_tx_*
  // after the next edge; with nothing accepted, valid/sop/eop drop and
  // data/mod hold.
  task automatic mon();
    if (!rst_n) begin
      armed = 1'b0; pv = 1'b0; last_d = '0; last_m = '0; acc_src = -1;
      return;
    end
    if (armed) begin
      if (pv) begin
        chk("fwd_val", pkt_tx_val, 1);
        chk("fwd_sop", pkt_tx_sop, pb.sop);
        chk("fwd_eop", pkt_tx_eop, pb.eop);
        chk("fwd_data", pkt_tx_data, pb.d);
        chk("fwd_mod", pkt_tx_mod, pb.eop ? pb.mod : 3'b0);
        last_d = pb.d;
        last_m = pb.eop ? pb.mod : 3'b0;
      end else begin
        chk("idle_val", pkt_tx_val, 0);
        chk("idle_sop", pkt_tx_sop, 0);
        chk("idle_eop", pkt_tx_eop, 0);
        chk("hold_data", pkt_tx_data, last_d);
        chk("hold_mod", pkt_tx_mod, last_m);
      end
    end
    chk("rdy_onehot", ($countones(src_ready) <= 1), 1);
    chk("rdy_full", pkt_tx_full ? src_ready : 4'b0, 0);
    acc_src = -1;
    for (int s = 0; s < N; s++) if (src_val[s] && src_ready[s]) acc_src = s;
    pv = (acc_src >= 0);
    if (pv) begin
      pb.d   = src_data[64*acc_src +: 64];
      pb.sop = src_sop[acc_src];
      pb.eop = src_eop[acc_src];
      pb.mod = src_mod[3*acc_src +: 3];
    end
    armed = 1'b1;
  endtask

  task automatic step();
    obeat_t o;
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n && pkt_tx_val) begin
      o.d = pkt_tx_data; o.sop = pkt_tx_sop; o.eop = pkt_tx_eop; o.mod = pkt_tx_mod;
      o.g = int'(grant_idx); o.cyc = cyc;
      outq.push_back(o);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Sources replay their queued beats; sop beats are always offered, other
  // beats optionally with random valid gaps. pkt_tx_full follows a fixed
  // window plus an optional random rate.
  task automatic run(input bit rnd, input int full_pct, input int fs, input int fl,
                     input int late_src, input int late_cyc);
    int c;
    int tail;
    bit v;
    bit empty;
    c = 0;
    tail = 0;
    while (tail < 3) begin
      for (int s = 0; s < N; s++) begin
        v = 1'b0;
        if (srcq[s].size() > 0 && !(s == late_src && c < late_cyc)) begin
          v = srcq[s][0].sop || !rnd || ($urandom_range(0, 3) != 0);
          put(s, srcq[s][0], v);
        end else begin
          put(s, mk(64'h0, 1'b0, 1'b0, 3'h0), 1'b0);
        end
      end
      pkt_tx_full = (c >= fs && c < fs + fl) || (int'($urandom_range(0, 99)) < full_pct);
      step();
      if (acc_src >= 0) void'(srcq[acc_src].pop_front());
      c++;
      empty = 1'b1;
      for (int s = 0; s < N; s++) if (srcq[s].size() > 0) empty = 1'b0;
      if (empty) tail++;
      if (c > 4000) begin
        chk("run_timeout", c, 0);
        tail = 3;
      end
    end
    clr();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sbeat_t expq [$];
    int     expg [$];
    sbeat_t b;
    int     ptr, pick, npk, len, rem, n;

    rst_n = 1'b0;
    clr();
    step();
    step();
    chk("rst_val", pkt_tx_val, 0);
    chk("rst_sop", pkt_tx_sop, 0);
    chk("rst_eop", pkt_tx_eop, 0);
    chk("rst_mod", pkt_tx_mod, 0);
    chk("rst_data", pkt_tx_data, 0);
    chk("rst_rdy", src_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_cnt", pkt_cnt, 0);
    rst_n = 1'b1;
    step();

    // Reset in the middle of a packet from source 0.
    put(0, mk(64'h11, 1'b1, 1'b0, 3'h0), 1'b1);
    step();
    chk("t1_busy", busy, 1);
    chk("t1_grant", grant_idx, 0);
    chk("t1_noval", pkt_tx_val, 0);
    #1 chk("t1_rdy", src_ready, 4'b0001);
    step();
    chk("t1_b1_val", pkt_tx_val, 1);
    chk("t1_b1_sop", pkt_tx_sop, 1);
    chk("t1_b1_data", pkt_tx_data, 64'h11);
    put(0, mk(64'h22, 1'b0, 1'b0, 3'h0), 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_r_val", pkt_tx_val, 0);
    chk("t1_r_sop", pkt_tx_sop, 0);
    chk("t1_r_data", pkt_tx_data, 0);
    chk("t1_r_rdy", src_ready, 0);
    chk("t1_r_busy", busy, 0);
    chk("t1_r_cnt", pkt_cnt, 0);
    clr();
    step();
    step();
    rst_n = 1'b1;
    step();
    outq.delete();
    srcq[0].push_back(mk(64'h11, 1'b1, 1'b0, 3'h5));
    srcq[0].push_back(mk(64'h22, 1'b0, 1'b0, 3'h5));
    srcq[0].push_back(mk(64'h33, 1'b0, 1'b1, 3'h5));
    run(1'b0, 0, 0, 0, -1, 0);
    chk("t1_nbeats", outq.size(), 3);
    if (outq.size() == 3) begin
      chk("t1_p_sop", outq[0].sop, 1);
      chk("t1_p_d0", outq[0].d, 64'h11);
      chk("t1_p_mod0", outq[0].mod, 0);
      chk("t1_p_d2", outq[2].d, 64'h33);
      chk("t1_p_eop", outq[2].eop, 1);
      chk("t1_p_mod2", outq[2].mod, 5);
    end
    exp_cnt = 1;
    chk("t1_cnt", pkt_cnt, exp_cnt);

    // All four sources request single-beat packets at once from pointer 0.
    do_reset();
    exp_cnt = 0;
    outq.delete();
    for (int s = 0; s < N; s++) srcq[s].push_back(mk(64'(s), 1'b1, 1'b1, 3'(s + 1)));
    run(1'b0, 0, 0, 0, -1, 0);
    chk("t2_n", outq.size(), 4);
    for (int i = 0; i < outq.size() && i < 4; i++) begin
      chk("t2_order", outq[i].d, 64'(i));
      chk("t2_grant", outq[i].g, i);
      if (i > 0) chk("t2_gap", outq[i].cyc - outq[i-1].cyc, 2);
    end
    exp_cnt = 4;
    chk("t2_cnt", pkt_cnt, exp_cnt);

    // Source 2, eight beats, pkt_tx_full high for five cycles from beat 3.
    outq.delete();
    for (int i = 0; i < 8; i++) srcq[2].push_back(mk(64'(i + 1), i == 0, i == 7, 3'h3));
    run(1'b0, 0, 3, 5, -1, 0);
    chk("t3_n", outq.size(), 8);
    for (int i = 0; i < outq.size() && i < 8; i++) begin
      chk("t3_data", outq[i].d, 64'(i + 1));
      chk("t3_sop", outq[i].sop, i == 0);
      chk("t3_eop", outq[i].eop, i == 7);
      chk("t3_mod", outq[i].mod, (i == 7) ? 3 : 0);
      chk("t3_grant", outq[i].g, 2);
    end
    if (outq.size() >= 3) chk("t3_stall", outq[2].cyc - outq[1].cyc, 6);
    exp_cnt = 5;
    chk("t3_cnt", pkt_cnt, exp_cnt);

    // Source 1 requests while source 3 is mid-packet.
    outq.delete();
    for (int i = 0; i < 4; i++) srcq[3].push_back(mk(64'h30 + 64'(i), i == 0, i == 3, 3'h7));
    for (int i = 0; i < 2; i++) srcq[1].push_back(mk(64'h10 + 64'(i), i == 0, i == 1, 3'h2));
    run(1'b0, 0, 0, 0, 1, 2);
    chk("t4_n", outq.size(), 6);
    for (int i = 0; i < outq.size() && i < 6; i++) begin
      chk("t4_data", outq[i].d, (i < 4) ? 64'h30 + 64'(i) : 64'h10 + 64'(i - 4));
      chk("t4_grant", outq[i].g, (i < 4) ? 3 : 1);
    end
    if (outq.size() >= 5) chk("t4_gap", outq[4].cyc - outq[3].cyc, 2);
    exp_cnt = 7;
    chk("t4_cnt", pkt_cnt, exp_cnt);

    // Source 0 holds valid without sop: never granted.
    clr();
    put(0, mk(64'hDEAD, 1'b0, 1'b0, 3'h0), 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_busy", busy, 0);
      chk("t5_val", pkt_tx_val, 0);
      chk("t5_rdy", src_ready, 0);
    end
    clr();
    step();

    // Randomized packets from all sources; expected order follows the
    // round-robin rule starting after source 1 (last packet owner).
    rem = 0;
    for (int s = 0; s < N; s++) begin
      npk = $urandom_range(1, 3);
      for (int p = 0; p < npk; p++) begin
        len = $urandom_range(1, 5);
        for (int k = 0; k < len; k++) begin
          b = mk({$urandom, $urandom}, k == 0, k == len - 1, 3'($urandom_range(0, 7)));
          srcq[s].push_back(b);
          refq[s].push_back(b);
        end
        rem++;
      end
    end
    n = rem;
    ptr = 2;
    while (rem > 0) begin
      pick = -1;
      for (int k = 0; k < N; k++) if (pick < 0 && refq[(ptr + k) % N].size() > 0) pick = (ptr + k) % N;
      do begin
        b = refq[pick].pop_front();
        expq.push_back(b);
        expg.push_back(pick);
      end while (!b.eop);
      ptr = (pick + 1) % N;
      rem--;
    end
    outq.delete();
    run(1'b1, 20, 0, 0, -1, 0);
    chk("rnd_n", outq.size(), expq.size());
    for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
      chk("rnd_data", outq[i].d, expq[i].d);
      chk("rnd_sop", outq[i].sop, expq[i].sop);
      chk("rnd_eop", outq[i].eop, expq[i].eop);
      chk("rnd_mod", outq[i].mod, expq[i].eop ? expq[i].mod : 3'b0);
      chk("rnd_grant", outq[i].g, expg[i]);
      if (i > 0 && outq[i-1].eop) chk("rnd_gap", (outq[i].cyc - outq[i-1].cyc) >= 2, 1);
    end
    exp_cnt = exp_cnt + n;
    chk("rnd_cnt", pkt_cnt, exp_cnt);

    // Counter wrap.
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    step();
    release dut.pkt_cnt_q;
    step();
    chk("wrap_pre", pkt_cnt, 32'hFFFF_FFFF);
    srcq[0].push_back(mk(64'hABCD, 1'b1, 1'b1, 3'h1));
    run(1'b0, 0, 0, 0, -1, 0);
    chk("wrap_cnt", pkt_cnt, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
